// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use hazard detection and branch-flush
// control. Each cycle the stage either captures the fetched instruction
// (RUN), holds its contents while a bubble goes into ID/EX (STALL), or
// squashes the fetched instruction on a taken branch (FLUSH). It also keeps
// saturating counters of stall and flush events.
//
// Handshake: this stage has no valid/ready pair. ValidOut marks a real,
// non-squashed instruction in InstructionOut. PCWriteOut is the
// back-pressure signal to fetch: when it is low, the fetched instruction is
// not consumed and must be presented again on the next cycle.
module if_id_hazard_stage #(
   parameter logic [31:0] NOP_WORD = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      InstructionIn,
   input  logic [31:0]      PCAddResultIn,
   input  logic             IDEXMemReadIn,
   input  logic [4:0]       IDEXRtRegIn,
   input  logic             BranchTakenIn,
   output logic [31:0]      InstructionOut,
   output logic [31:0]      PCAddResultOut,
   output logic             ValidOut,
   output logic             PCWriteOut,
   output logic             IDEXFlushOut,
   output logic             StallOut,
   output logic [CNT_W-1:0] StallCountOut,
   output logic [CNT_W-1:0] FlushCountOut
);

   // Per-cycle operating mode. It is combinational, so there is no state
   // register; the mode is derived fresh each cycle.
   typedef enum logic [1:0] {
      MODE_RUN   = 2'd0,
      MODE_STALL = 2'd1,
      MODE_FLUSH = 2'd2
   } mode_e;

   logic [31:0]      instr_q, instr_d;
   logic [31:0]      pc_q, pc_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic             hazard;
   mode_e            mode;

   // Load-use hazard: the load in ID/EX writes a register that the
   // instruction in decode reads. The rt field is always compared, even for
   // formats that do not read rt. This is conservative and only costs a
   // bubble.
   always_comb begin
      hazard = 1'b0;
      if (IDEXMemReadIn && valid_q && (IDEXRtRegIn != 5'd0) &&
          ((IDEXRtRegIn == instr_q[25:21]) || (IDEXRtRegIn == instr_q[20:16])))
         hazard = 1'b1;
   end

   // Mode selection. A taken branch takes priority over a hazard, because
   // the instruction that would have stalled is squashed anyway.
   always_comb begin
      mode = MODE_RUN;
      if (BranchTakenIn)
         mode = MODE_FLUSH;
      else if (hazard)
         mode = MODE_STALL;
   end

   // Control outputs and next-state values for the register and counters.
   always_comb begin
      PCWriteOut   = 1'b1;
      IDEXFlushOut = 1'b0;
      StallOut     = 1'b0;
      instr_d      = InstructionIn;
      pc_d         = PCAddResultIn;
      valid_d      = 1'b1;
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      case (mode)
         MODE_FLUSH: begin
            IDEXFlushOut = 1'b1;
            instr_d      = NOP_WORD;
            pc_d         = 32'd0;
            valid_d      = 1'b0;
            if (flush_cnt_q != {CNT_W{1'b1}})
               flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
         MODE_STALL: begin
            PCWriteOut   = 1'b0;
            IDEXFlushOut = 1'b1;
            StallOut     = 1'b1;
            instr_d      = instr_q;
            pc_d         = pc_q;
            valid_d      = valid_q;
            if (stall_cnt_q != {CNT_W{1'b1}})
               stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         default: begin
            // RUN: take the defaults assigned above.
         end
      endcase
   end

   // IF/ID register and event counters. Reset is asynchronous.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q     <= NOP_WORD;
         pc_q        <= 32'd0;
         valid_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         instr_q     <= instr_d;
         pc_q        <= pc_d;
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign InstructionOut = instr_q;
   assign PCAddResultOut = pc_q;
   assign ValidOut       = valid_q;
   assign StallCountOut  = stall_cnt_q;
   assign FlushCountOut  = flush_cnt_q;

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Testbench for if_id_hazard_stage. It applies a directed vector table,
// hand-written reset sequences, randomized traffic checked against a
// behavioural model, and a flush-counter saturation run.
module tb_if_id_hazard_stage;

   localparam int CNT_W = 16;
   localparam logic [31:0] NOP = 32'h0000_0000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [31:0]      instr_in, pc_in;
   logic             mr_in, br_in;
   logic [4:0]       rt_in;
   logic [31:0]      instr_out, pc_out;
   logic             valid_out, pcw_out, flush_out, stall_out;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   if_id_hazard_stage #(.NOP_WORD(NOP), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .InstructionIn(instr_in), .PCAddResultIn(pc_in),
      .IDEXMemReadIn(mr_in), .IDEXRtRegIn(rt_in), .BranchTakenIn(br_in),
      .InstructionOut(instr_out), .PCAddResultOut(pc_out), .ValidOut(valid_out),
      .PCWriteOut(pcw_out), .IDEXFlushOut(flush_out), .StallOut(stall_out),
      .StallCountOut(stall_cnt), .FlushCountOut(flush_cnt)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // The model state is what decode should currently see, plus plain integer
   // event counts. The counts are clamped to the counter range only when
   // they are compared.
   logic [31:0] m_instr, m_pc;
   logic        m_valid;
   int          m_stalls, m_flushes;

   function automatic logic [31:0] sat(input int n);
      return (n > 65535) ? 32'd65535 : n;
   endfunction

   task automatic model_reset();
      m_instr = NOP; m_pc = 32'd0; m_valid = 1'b0; m_stalls = 0; m_flushes = 0;
   endtask

   // A hazard exists when the load target is a nonzero register that the
   // live instruction in decode names as rs or rt.
   function automatic bit model_hazard();
      return mr_in && m_valid && (rt_in != 5'd0) &&
             (rt_in == m_instr[25:21] || rt_in == m_instr[20:16]);
   endfunction

   task automatic chk_regs(input string tag);
      chk({tag, ".instr"}, instr_out, m_instr);
      chk({tag, ".pc"}, pc_out, m_pc);
      chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, m_valid});
      chk({tag, ".stall_cnt"}, {16'd0, stall_cnt}, sat(m_stalls));
      chk({tag, ".flush_cnt"}, {16'd0, flush_cnt}, sat(m_flushes));
   endtask

   // Drive one cycle of inputs. This is called at posedge+1. When do_check
   // is set, it checks the combinational outputs first and then the
   // registered outputs after the edge.
   task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic mr,
                       input logic [4:0] rt, input logic br, input bit do_check);
      bit exp_pcw, exp_fl, exp_st, hz;
      instr_in = ins; pc_in = pc; mr_in = mr; rt_in = rt; br_in = br;
      #1;
      hz = model_hazard();
      exp_pcw = br || !hz;
      exp_fl  = br || hz;
      exp_st  = !br && hz;
      if (do_check) begin
         chk("rnd.pcwrite", {31'd0, pcw_out}, {31'd0, exp_pcw});
         chk("rnd.idexflush", {31'd0, flush_out}, {31'd0, exp_fl});
         chk("rnd.stall", {31'd0, stall_out}, {31'd0, exp_st});
      end
      if (br) begin
         m_instr = NOP; m_pc = 32'd0; m_valid = 1'b0; m_flushes++;
      end else if (hz) begin
         m_stalls++;
      end else begin
         m_instr = ins; m_pc = pc; m_valid = 1'b1;
      end
      @(posedge clk); #1;
      if (do_check) chk_regs("rnd");
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [31:0] instr_in;
      logic [31:0] pc_in;
      logic        mr;
      logic [4:0]  rt;
      logic        br;
      logic        e_pcw;
      logic        e_fl;
      logic        e_st;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic        e_valid;
      logic [15:0] e_sc;
      logic [15:0] e_fc;
   } vec_t;

   vec_t vecs[12];

   initial begin
      // Rows: inputs, then expected comb outputs, then expected registers after the edge.
      vecs[0]  = '{32'h2009_0005, 32'h04, 0,  0, 0, 1, 0, 0, 32'h2009_0005, 32'h04, 1, 0, 0}; // first capture
      vecs[1]  = '{32'h0128_5020, 32'h08, 0,  0, 0, 1, 0, 0, 32'h0128_5020, 32'h08, 1, 0, 0}; // add $10,$9,$8
      vecs[2]  = '{32'h0000_1111, 32'h0C, 1,  9, 0, 0, 1, 1, 32'h0128_5020, 32'h08, 1, 1, 0}; // load-use on rs
      vecs[3]  = '{32'h0128_5020, 32'h0C, 0,  9, 0, 1, 0, 0, 32'h0128_5020, 32'h0C, 1, 1, 0}; // run resumes
      vecs[4]  = '{32'h0000_0020, 32'h10, 1, 11, 0, 1, 0, 0, 32'h0000_0020, 32'h10, 1, 1, 0}; // Rt 11: no match
      vecs[5]  = '{32'h2009_0005, 32'h14, 1,  0, 0, 1, 0, 0, 32'h2009_0005, 32'h14, 1, 1, 0}; // Rt 0 vs $0 user
      vecs[6]  = '{32'h0000_1111, 32'h18, 1,  9, 1, 1, 1, 0, 32'h0000_0000, 32'h00, 0, 1, 1}; // branch + hazard
      vecs[7]  = '{32'h0128_5020, 32'h1C, 1,  9, 0, 1, 0, 0, 32'h0128_5020, 32'h1C, 1, 1, 1}; // squashed slot
      vecs[8]  = '{32'h0000_2222, 32'h20, 0,  0, 1, 1, 1, 0, 32'h0000_0000, 32'h00, 0, 1, 2}; // plain branch
      vecs[9]  = '{32'h0128_5020, 32'h24, 0,  0, 0, 1, 0, 0, 32'h0128_5020, 32'h24, 1, 1, 2};
      vecs[10] = '{32'h0000_3333, 32'h28, 1,  8, 0, 0, 1, 1, 32'h0128_5020, 32'h24, 1, 2, 2}; // load-use on rt
      vecs[11] = '{32'h0000_3333, 32'h28, 0,  8, 0, 1, 0, 0, 32'h0000_3333, 32'h28, 1, 2, 2};
   end

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0;
      instr_in = '0; pc_in = '0; mr_in = 1'b0; rt_in = '0; br_in = 1'b0;
      model_reset();

      // Reset held with random inputs: registers stay at reset values.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         instr_in = $urandom; pc_in = $urandom; mr_in = 1'($urandom);
         rt_in = 5'($urandom); br_in = 1'($urandom);
         #1;
         chk_regs("reset_hold");
         chk("reset_hold.pcwrite", {31'd0, pcw_out}, 32'd1);
         chk("reset_hold.idexflush", {31'd0, flush_out}, {31'd0, br_in});
         chk("reset_hold.stall", {31'd0, stall_out}, 32'd0);
      end

      // Release reset between edges, then apply the directed table.
      @(posedge clk); #1;
      rst_n = 1'b1;
      foreach (vecs[i]) begin
         instr_in = vecs[i].instr_in; pc_in = vecs[i].pc_in; mr_in = vecs[i].mr;
         rt_in = vecs[i].rt; br_in = vecs[i].br;
         #1;
         chk($sformatf("vec%0d.pcwrite", i), {31'd0, pcw_out}, {31'd0, vecs[i].e_pcw});
         chk($sformatf("vec%0d.idexflush", i), {31'd0, flush_out}, {31'd0, vecs[i].e_fl});
         chk($sformatf("vec%0d.stall", i), {31'd0, stall_out}, {31'd0, vecs[i].e_st});
         @(posedge clk); #1;
         chk($sformatf("vec%0d.instr", i), instr_out, vecs[i].e_instr);
         chk($sformatf("vec%0d.pc", i), pc_out, vecs[i].e_pc);
         chk($sformatf("vec%0d.valid", i), {31'd0, valid_out}, {31'd0, vecs[i].e_valid});
         chk($sformatf("vec%0d.stall_cnt", i), {16'd0, stall_cnt}, {16'd0, vecs[i].e_sc});
         chk($sformatf("vec%0d.flush_cnt", i), {16'd0, flush_cnt}, {16'd0, vecs[i].e_fc});
      end
      m_instr = 32'h0000_3333; m_pc = 32'h28; m_valid = 1'b1; m_stalls = 2; m_flushes = 2;

      // Reset asserted mid-stall clears everything immediately.
      step(32'h0128_5020, 32'h2C, 1'b0, 5'd0, 1'b0, 1'b1);
      instr_in = 32'h0000_4444; pc_in = 32'h30; mr_in = 1'b1; rt_in = 5'd9; br_in = 1'b0;
      #1;
      chk("midstall.stall", {31'd0, stall_out}, 32'd1);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_regs("midstall_rst");
      chk("midstall_rst.stall", {31'd0, stall_out}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Randomized traffic against the model. The load target is biased
      // toward the decode instruction's fields so that hazards are common.
      for (int i = 0; i < 2000; i++) begin
         logic [4:0] rt;
         int sel;
         sel = $urandom_range(0, 3);
         rt = (sel == 0) ? m_instr[25:21] : (sel == 1) ? m_instr[20:16] : 5'($urandom);
         step($urandom, $urandom, 1'($urandom_range(0, 2) != 0), rt,
              1'($urandom_range(0, 7) == 0), 1'b1);
      end

      // Flush counter saturation.
      rst_n = 1'b0; #1; model_reset(); chk_regs("sat_rst");
      @(posedge clk); #1; rst_n = 1'b1;
      for (int i = 0; i < 65540; i++)
         step($urandom, $urandom, 1'b0, 5'd0, 1'b1, 1'b0);
      chk("sat.flush_cnt", {16'd0, flush_cnt}, 32'h0000_FFFF);
      step(32'h1234_5678, 32'h40, 1'b0, 5'd0, 1'b1, 1'b1);
      chk("sat.hold", {16'd0, flush_cnt}, 32'h0000_FFFF);

      // An asynchronous reset pulse in the middle of the flush stream.
      br_in = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_regs("sat_async_rst");
      @(posedge clk); #1;
      chk("sat_async_rst.held", {16'd0, flush_cnt}, 32'd0);
      rst_n = 1'b1;
      step(32'h2009_0005, 32'h4, 1'b0, 5'd0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
